// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: types and constants shared by the PC sequencer and its
// return-address stack.
//   seq_state_e : sequencer FSM states (RUN / WAIT_IN / MULDIV)
//   sel_t/SEL_* : next-PC source select encoding
//   ptrW()      : pointer width for a power-of-2 stack depth
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_IN = 2'd1,
    MULDIV  = 2'd2
  } seq_state_e;

  localparam int RAS_DEPTH_DFLT = 4;
  localparam int RAS_PTR_W      = $clog2(RAS_DEPTH_DFLT);

  typedef logic [2:0] sel_t;
  localparam sel_t SEL_SEQ  = 3'd0;  // pc + 1
  localparam sel_t SEL_IMM  = 3'd1;  // {pc hi, imm}
  localparam sel_t SEL_JR   = 3'd2;  // {pc hi, rs_val lo}
  localparam sel_t SEL_RET  = 3'd3;  // top of return-address stack
  localparam sel_t SEL_ZERO = 3'd4;  // restart
  localparam sel_t SEL_HOLD = 3'd5;  // pc unchanged

  function automatic int ptrW(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// ret_addr_stack: circular return-address stack.
//   clock, reset : posedge clock, async active-low reset
//   clr          : synchronous empty
//   push/pushData: push an address; when full the oldest entry is overwritten
//   pop          : pop when non-empty; ignored when empty
//   top          : current top (0 when empty); full/empty status flags
module ret_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] pushData,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = ptrW(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wrPtr;   // next free slot; wraps, so a full push lands on the oldest
  logic [PW-1:0] topPtr;
  logic [CW-1:0] count;

  assign topPtr = wrPtr - 1'b1;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign top    = empty ? '0 : mem[topPtr];

  always_ff @(posedge clock) begin
    if (push && !clr) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      count <= '0;
    end else if (clr) begin
      wrPtr <= '0;
      count <= '0;
    end else if (push) begin
      wrPtr <= wrPtr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wrPtr <= topPtr;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generator / sequencing controller.
//   clock, reset          : posedge clock, async active-low reset
//   zero_pc               : synchronous restart (highest priority)
//   pause_req/button_pulse: IN instruction holds until a button pulse
//   muldiv_start          : MUL/DIV occupies MULDIV_CYCLES cycles
//   branch_en/taken, jump_en, jump_reg_en, call_en, ret_en : redirects
//   imm, rs_val           : target fields
//   pc, pc_plus1          : current PC and its increment
//   halted, stalled       : WAIT_IN / MULDIV state decode
//   ras_overflow/underflow: sticky return-stack error flags
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W          = 32,
  parameter int IMM_W         = 11,
  parameter int JR_W          = 26,
  parameter int RAS_DEPTH     = 4,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zero_pc,
  input  logic             pause_req,
  input  logic             button_pulse,
  input  logic             muldiv_start,
  input  logic             branch_en,
  input  logic             branch_taken,
  input  logic             jump_en,
  input  logic             jump_reg_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  rs_val,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic             halted,
  output logic             stalled,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  // mdcnt counts down from MULDIV_CYCLES-2; the RUN cycle that sees
  // muldiv_start is the first of the held cycles.
  localparam int MD_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES - 1) : 1;
  localparam logic [MD_W-1:0] MD_INIT =
    MD_W'((MULDIV_CYCLES >= 2) ? (MULDIV_CYCLES - 2) : 0);

  seq_state_e      state, nState;
  logic [MD_W-1:0] mdcnt, mdNext;
  sel_t            sel;
  logic [PC_W-1:0] pcNext, immTarget, jrTarget, rasTop;
  logic            rasPush, rasPop, rasFull, rasEmpty, setOvf, setUnf;

  assign pc_plus1  = pc + PC_W'(1);
  assign immTarget = {pc[PC_W-1:IMM_W], imm};

  generate
    if (JR_W == PC_W) begin : g_jrFull
      assign jrTarget = rs_val;
    end else begin : g_jrPart
      logic unusedRsHi;
      assign unusedRsHi = ^rs_val[PC_W-1:JR_W];
      assign jrTarget   = {pc[PC_W-1:JR_W], rs_val[JR_W-1:0]};
    end
  endgenerate

  ret_addr_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clock    (clock),
    .reset    (reset),
    .clr      (zero_pc),
    .push     (rasPush),
    .pop      (rasPop),
    .pushData (pc_plus1),
    .top      (rasTop),
    .full     (rasFull),
    .empty    (rasEmpty)
  );

  always_comb begin
    sel     = SEL_SEQ;
    nState  = state;
    mdNext  = mdcnt;
    rasPush = 1'b0;
    rasPop  = 1'b0;
    setOvf  = 1'b0;
    setUnf  = 1'b0;
    if (zero_pc) begin
      sel    = SEL_ZERO;
      nState = RUN;
      mdNext = '0;
    end else begin
      case (state)
        RUN: begin
          if (pause_req) begin
            sel    = SEL_HOLD;
            nState = WAIT_IN;
          end else if (muldiv_start) begin
            if (MULDIV_CYCLES > 1) begin
              sel    = SEL_HOLD;
              nState = MULDIV;
              mdNext = MD_INIT;
            end
          end else if (ret_en) begin
            // ret outranks call, so a simultaneous call never pushes
            if (!rasEmpty) begin
              sel    = SEL_RET;
              rasPop = 1'b1;
            end else begin
              setUnf = 1'b1;
            end
          end else if (call_en) begin
            sel     = SEL_IMM;
            rasPush = 1'b1;
            setOvf  = rasFull;
          end else if (jump_en) begin
            sel = SEL_IMM;
          end else if (jump_reg_en) begin
            sel = SEL_JR;
          end else if (branch_en && branch_taken) begin
            sel = SEL_IMM;
          end
        end
        WAIT_IN: begin
          if (button_pulse) nState = RUN;
          else              sel    = SEL_HOLD;
        end
        MULDIV: begin
          if (mdcnt == '0) begin
            nState = RUN;
          end else begin
            sel    = SEL_HOLD;
            mdNext = mdcnt - 1'b1;
          end
        end
        default: begin
          sel    = SEL_ZERO;
          nState = RUN;
          mdNext = '0;
        end
      endcase
    end
  end

  always_comb begin
    case (sel)
      SEL_IMM:  pcNext = immTarget;
      SEL_JR:   pcNext = jrTarget;
      SEL_RET:  pcNext = rasTop;
      SEL_ZERO: pcNext = '0;
      SEL_HOLD: pcNext = pc;
      default:  pcNext = pc_plus1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc            <= '0;
      state         <= RUN;
      mdcnt         <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pcNext;
      state         <= nState;
      mdcnt         <= mdNext;
      ras_overflow  <= ras_overflow  | setOvf;
      ras_underflow <= ras_underflow | setUnf;
    end
  end

  // straight decode of the state register
  assign halted  = (state == WAIT_IN);
  assign stalled = (state == MULDIV);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        zero_pc = 0, pause_req = 0, button_pulse = 0, muldiv_start = 0;
  logic        branch_en = 0, branch_taken = 0, jump_en = 0, jump_reg_en = 0;
  logic        call_en = 0, ret_en = 0;
  logic [10:0] imm = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] pc, pc_plus1;
  logic        halted, stalled, ras_overflow, ras_underflow;

  // small instance: PC_W==JR_W, single-cycle MUL/DIV, wraparound reachable
  logic       bMd = 0, bJr = 0;
  logic [7:0] bRs = '0;
  logic [3:0] bImm = '0;
  logic [7:0] bPc, bPcPlus1;
  logic       bHalted, bStalled, bOvf, bUnf;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .zero_pc(zero_pc), .pause_req(pause_req),
    .button_pulse(button_pulse), .muldiv_start(muldiv_start),
    .branch_en(branch_en), .branch_taken(branch_taken), .jump_en(jump_en),
    .jump_reg_en(jump_reg_en), .call_en(call_en), .ret_en(ret_en),
    .imm(imm), .rs_val(rs_val), .pc(pc), .pc_plus1(pc_plus1),
    .halted(halted), .stalled(stalled), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  pc_sequencer #(.PC_W(8), .IMM_W(4), .JR_W(8), .RAS_DEPTH(2), .MULDIV_CYCLES(1)) dut2 (
    .clock(clock), .reset(reset), .zero_pc(1'b0), .pause_req(1'b0),
    .button_pulse(1'b0), .muldiv_start(bMd), .branch_en(1'b0),
    .branch_taken(1'b0), .jump_en(1'b0), .jump_reg_en(bJr), .call_en(1'b0),
    .ret_en(1'b0), .imm(bImm), .rs_val(bRs), .pc(bPc), .pc_plus1(bPcPlus1),
    .halted(bHalted), .stalled(bStalled), .ras_overflow(bOvf),
    .ras_underflow(bUnf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_stalled", stalled, 0);
    check("rst_ovf", ras_overflow, 0);
    check("rst_unf", ras_underflow, 0);
    @(negedge clock) reset = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("seq_%0d", i), pc, i);
    end
    check("seq_plus1", pc_plus1, 6);

    // async reset mid-cycle
    #2 reset = 1'b0;
    #1 check("async_rst_pc", pc, 0);
    @(negedge clock) reset = 1'b1;

    // branch taken / not taken around pc=0x803
    jump_reg_en = 1; rs_val = 32'h803; tick(); jump_reg_en = 0;
    check("jr_803", pc, 32'h803);
    branch_en = 1; branch_taken = 1; imm = 11'h005; tick();
    check("br_taken", pc, 32'h805);
    branch_en = 0; jump_reg_en = 1; tick(); jump_reg_en = 0;
    branch_en = 1; branch_taken = 0; tick(); branch_en = 0;
    check("br_not_taken", pc, 32'h804);

    // MUL/DIV stall at pc=10
    zero_pc = 1; tick(); zero_pc = 0;
    check("zero_pc", pc, 0);
    jump_en = 1; imm = 11'd10; tick(); jump_en = 0;
    check("jmp_10", pc, 10);
    muldiv_start = 1; tick(); muldiv_start = 0;
    check("md_pc_1", pc, 10);
    check("md_stall_1", stalled, 1);
    jump_en = 1; imm = 11'h55;  // must be ignored while stalled
    tick(); check("md_pc_2", pc, 10); check("md_stall_2", stalled, 1);
    tick(); check("md_pc_3", pc, 10); check("md_stall_3", stalled, 1);
    tick(); jump_en = 0;
    check("md_pc_done", pc, 11);
    check("md_stall_done", stalled, 0);

    // IN instruction at pc=20
    jump_en = 1; imm = 11'd20; tick(); jump_en = 0;
    check("jmp_20", pc, 20);
    pause_req = 1; button_pulse = 1; tick(); pause_req = 0; button_pulse = 0;
    check("in_halted", halted, 1);
    check("in_pc_same_pulse", pc, 20);
    jump_en = 1; imm = 11'h77; tick(); jump_en = 0;
    check("in_pc_hold", pc, 20);
    button_pulse = 1; tick(); button_pulse = 0;
    check("in_release_pc", pc, 21);
    check("in_release_halted", halted, 0);

    // RAS overflow / underflow
    zero_pc = 1; tick(); zero_pc = 0;
    tick();
    check("ras_start_pc", pc, 1);
    for (int k = 0; k < 5; k++) begin
      call_en = 1; imm = 11'(2 * k + 2); tick(); call_en = 0;
      check($sformatf("call_%0d", k), pc, 2 * k + 2);
      check($sformatf("ovf_%0d", k), ras_overflow, (k == 4) ? 1 : 0);
      if (k < 4) tick();
    end
    ret_en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("ret_%0d", k), pc, 10 - 2 * k);
    end
    check("unf_before", ras_underflow, 0);
    tick(); ret_en = 0;
    check("ret_empty_pc", pc, 5);
    check("unf_after", ras_underflow, 1);

    // ret beats call; the call must not push
    call_en = 1; imm = 11'h40; tick();
    check("call_40", pc, 32'h40);
    ret_en = 1; imm = 11'h50; tick(); call_en = 0;
    check("ret_wins", pc, 6);
    tick(); ret_en = 0;
    check("no_push", pc, 7);

    // jump-register masking keeps pc upper bits
    jump_reg_en = 1; rs_val = 32'hFFFF_FFFF; tick(); jump_reg_en = 0;
    check("jr_mask", pc, 32'h03FF_FFFF);
    tick();
    check("seq_carry", pc, 32'h0400_0000);
    jump_reg_en = 1; tick(); jump_reg_en = 0;
    check("jr_keep_hi", pc, 32'h07FF_FFFF);
    jump_en = 1; imm = 11'h123; tick(); jump_en = 0;
    check("imm_keep_hi", pc, 32'h07FF_F923);

    // zero_pc during MUL/DIV
    muldiv_start = 1; tick(); muldiv_start = 0;
    check("md2_stall", stalled, 1);
    zero_pc = 1; tick(); zero_pc = 0;
    check("md2_zero_pc", pc, 0);
    check("md2_stalled", stalled, 0);
    check("md2_ovf_kept", ras_overflow, 1);
    check("md2_unf_kept", ras_underflow, 1);
    tick();
    check("md2_run", pc, 1);

    // small instance: full-width JR, wrap, single-cycle MUL/DIV
    bJr = 1; bRs = 8'hFF; tick(); bJr = 0;
    check("b_jr_full", bPc, 8'hFF);
    check("b_plus1_wrap", bPcPlus1, 8'h00);
    tick();
    check("b_wrap", bPc, 8'h00);
    bMd = 1; tick(); bMd = 0;
    check("b_md1_pc", bPc, 8'h01);
    check("b_md1_stall", bStalled, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
